// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default width
// and the saturated quotient returned on divide-by-zero / overflow.
package div_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DEF_W-1:0] Q_SAT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] r,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] t;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        t      = {r, bit_in};
        q_bit  = 1'b0;
        r_next = t[W-1:0];
        // The true difference is below the divisor, so the W-bit wrap is exact.
        if (t >= {1'b0, divisor}) begin
            q_bit  = 1'b1;
            r_next = t[W-1:0] - divisor;
        end
    end

endmodule

// File: rtl/simple_restoring_div_64by32.sv
// Sequential 2W-by-W restoring divider with valid/ready on both sides;
// one operation in flight, W iteration cycles on the normal path.
module simple_restoring_div_64by32
    import div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);

    state_t         state;
    // R < divisor between steps, so its MSB is always 0 and only W bits are kept.
    logic [W-1:0]   r;
    logic [W-1:0]   q;
    logic [W-1:0]   dvs;
    logic [CW-1:0]  count;
    logic           dz_pend;
    logic           ov_pend;
    logic [W-1:0]   r_next;
    logic           q_bit;

    div_step #(.W(W)) u_step (
        .r       (r),
        .bit_in  (q[W-1]),
        .divisor (dvs),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
            dz_pend   <= 1'b0;
            ov_pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvs      <= divisor;
                        if (divisor == '0) begin
                            dz_pend <= 1'b1;
                            ov_pend <= 1'b0;
                            q       <= {W{Q_SAT[0]}};
                            r       <= dividend[W-1:0];
                            state   <= DONE;
                        end else if (dividend[2*W-1:W] >= divisor) begin
                            dz_pend <= 1'b0;
                            ov_pend <= 1'b1;
                            q       <= {W{Q_SAT[0]}};
                            r       <= '0;
                            state   <= DONE;
                        end else begin
                            dz_pend <= 1'b0;
                            ov_pend <= 1'b0;
                            r       <= dividend[2*W-1:W];
                            q       <= dividend[W-1:0];
                            count   <= CW'(W - 1);
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r <= r_next;
                    q <= {q[W-2:0], q_bit};
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; afterwards wait for the consumer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        quotient  <= q;
                        remainder <= r;
                        div_zero  <= dz_pend;
                        overflow  <= ov_pend;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_restoring_div_64by32.sv
// Scoreboard bench for simple_restoring_div_64by32: directed cases, backpressure,
// mid-operation reset and randomized divisions against a plain-arithmetic model.
module tb_simple_restoring_div_64by32;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;
    logic          overflow;

    simple_restoring_div_64by32 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        int unsigned    acc_edge;
        int unsigned    lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cycle = 0;
    bit          seen = 1'b0;
    bit          ready_rand = 1'b0;
    bit          ready_force = 1'b1;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = ready_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                                input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dz, input logic ov);
        exp_t e;
        e.dvd = dvd; e.dvs = dvs; e.q = q; e.r = r; e.dz = dz; e.ov = ov;
        e.lat = (dz || ov) ? 1 : W + 1;
        e.acc_edge = 0;
        return e;
    endfunction

    // Reference: ordinary integer division on 64-bit values.
    function automatic exp_t ref_div(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, dvs};
        if (dvs == 0)
            return mk(dvd, dvs, '1, dvd[W-1:0], 1'b1, 1'b0);
        if (dvd >= (wide << W))
            return mk(dvd, dvs, '1, '0, 1'b0, 1'b1);
        return mk(dvd, dvs, W'(dvd / wide), W'(dvd % wide), 1'b0, 1'b0);
    endfunction

    task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input exp_t e);
        bit accepted = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc_edge = cycle + 1;
                sb.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready never high for dividend 0x%0h", dvd);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, in_ready=%0b", sb.size(), in_ready);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_quotient"},  64'(quotient),  64'd0);
        check({tag, "_remainder"}, 64'(remainder), 64'd0);
        check({tag, "_div_zero"},  64'(div_zero),  64'd0);
        check({tag, "_overflow"},  64'(overflow),  64'd0);
    endtask

    // Monitor: latency on the first valid cycle, full result on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid: out_valid with empty scoreboard");
                end else begin
                    check("latency", 64'(cycle - sb[0].acc_edge), 64'(sb[0].lat));
                end
            end
            if (out_valid && out_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: quotient 0x%0h", quotient);
                end else begin
                    mon_e = sb.pop_front();
                    check("quotient",  64'(quotient),  64'(mon_e.q));
                    check("remainder", 64'(remainder), 64'(mon_e.r));
                    check("div_zero",  64'(div_zero),  64'(mon_e.dz));
                    check("overflow",  64'(overflow),  64'(mon_e.ov));
                    if (!mon_e.dz && !mon_e.ov) begin
                        check("identity", 64'(quotient) * 64'(mon_e.dvs) + 64'(remainder), mon_e.dvd);
                        check("rem_lt_div", 64'(remainder < mon_e.dvs), 64'd1);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   hi;
        logic [W-1:0]   dv;
        logic [2*W-1:0] dd;
        exp_t           e;
        bit             got;

        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Directed cases with hand-computed results.
        issue(64'h0000_0001_0000_0000, 32'h2,
              mk(64'h0000_0001_0000_0000, 32'h2, 32'h8000_0000, 32'h0, 1'b0, 1'b0));
        issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,
              mk(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        issue(64'h7, 32'h3, mk(64'h7, 32'h3, 32'h2, 32'h1, 1'b0, 1'b0));
        issue(64'h1234_5678_9ABC_DEF0, 32'h0,
              mk(64'h1234_5678_9ABC_DEF0, 32'h0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0));
        issue(64'h0000_0005_0000_0000, 32'h5,
              mk(64'h0000_0005_0000_0000, 32'h5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1));
        wait_drain();

        // Backpressure: result held, stray input ignored, in_ready returns after handshake.
        ready_force = 1'b0;
        issue(64'h0000_0003_1234_5678, 32'h10,
              mk(64'h0000_0003_1234_5678, 32'h10, 32'h3123_4567, 32'h8, 1'b0, 1'b0));
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", 64'(got), 64'd1);
        in_valid = 1'b1;
        dividend = 64'h0000_0000_0000_0063;
        divisor  = 32'h5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_quotient",  64'(quotient),  64'h3123_4567);
            check("bp_remainder", 64'(remainder), 64'h8);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        check("hs_cycle_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("post_hs_in_ready",  64'(in_ready),  64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of an iteration sequence.
        issue(64'h0000_0000_FFFF_FFFF, 32'h10, ref_div(64'h0000_0000_FFFF_FFFF, 32'h10));
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        issue(64'd100, 32'd7, mk(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0));
        wait_drain();

        // Randomized operations with random consumer backpressure.
        ready_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 15))
                0: begin
                    dd = {$urandom, $urandom};
                    dv = '0;
                end
                1: begin
                    hi = $urandom;
                    if (hi == 0) hi = 1;
                    dv = (hi == 1) ? 32'd1 : $urandom_range(1, hi);
                    dd = {hi, 32'($urandom)};
                end
                default: begin
                    dv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom);
                    if (dv == 0) dv = 1;
                    hi = 32'($urandom) % dv;
                    dd = {hi, 32'($urandom)};
                end
            endcase
            e = ref_div(dd, dv);
            issue(dd, dv, e);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
